// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared FSM encodings and 48 MHz timing constants for button consumers
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DB_DOWN = 2'd1,
        ST_HELD    = 2'd2,
        ST_DB_UP   = 2'd3
    } btn_state_e;

    localparam int unsigned CLK_HZ_DEFAULT          = 48_000_000;
    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 65536;
    localparam int unsigned LONG_CYCLES_DEFAULT     = 16777216;

    // Never return a zero-width counter, even for a single-cycle debounce.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_event_decoder_input_sync.sv
// rtl/button_event_decoder_input_sync.sv - N-flop synchroniser with asynchronous reset to a chosen level
module button_event_decoder_input_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounces an active-low pad into a level plus press/release/long-press pulses
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_evt,
    output logic release_evt,
    output logic long_evt
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic btn_n_sync;
    logic btn;

    btn_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              pressed_q, pressed_d;
    logic              press_evt_q, press_evt_d;
    logic              release_evt_q, release_evt_d;
    logic              long_evt_q, long_evt_d;

    // Pad idles high through its pull-up, so the synchroniser resets to "released".
    button_event_decoder_input_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_n),
        .q_o (btn_n_sync)
    );

    assign btn = ~btn_n_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            db_cnt_q      <= '0;
            hold_cnt_q    <= '0;
            long_done_q   <= 1'b0;
            pressed_q     <= 1'b0;
            press_evt_q   <= 1'b0;
            release_evt_q <= 1'b0;
            long_evt_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            long_done_q   <= long_done_d;
            pressed_q     <= pressed_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
            long_evt_q    <= long_evt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        db_cnt_d      = db_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        long_done_d   = long_done_q;
        pressed_d     = pressed_q;
        press_evt_d   = 1'b0;
        release_evt_d = 1'b0;
        long_evt_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn) begin
                    state_d  = ST_DB_DOWN;
                    db_cnt_d = '0;
                end
            end
            ST_DB_DOWN: begin
                if (!btn) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    pressed_d   = 1'b1;
                    press_evt_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn) begin
                    state_d  = ST_DB_UP;
                    db_cnt_d = '0;
                end
            end
            ST_DB_UP: begin
                if (btn) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = ST_IDLE;
                    pressed_d     = 1'b0;
                    release_evt_d = 1'b1;
                    long_done_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold time keeps running through release bounce; an accepted release wins over a coincident long press.
        if (state_q == ST_HELD || state_q == ST_DB_UP) begin
            if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (hold_cnt_q == HOLD_LAST && !long_done_q && !release_evt_d) begin
                long_evt_d  = 1'b1;
                long_done_d = 1'b1;
            end
        end
    end

    assign pressed     = pressed_q;
    assign press_evt   = press_evt_q;
    assign release_evt = release_evt_q;
    assign long_evt    = long_evt_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed cycle-by-cycle bench for button_event_decoder
module tb_button_event_decoder;

    logic clk;
    logic rst;
    logic btn_n;
    logic pressed;
    logic press_evt;
    logic release_evt;
    logic long_evt;

    int checks;
    int errors;

    // exp = {pressed, press_evt, release_evt, long_evt}, held for every one of ncyc cycles
    typedef struct {
        logic        btn_n;
        int          ncyc;
        logic [3:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    button_event_decoder #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .pressed     (pressed),
        .press_evt   (press_evt),
        .release_evt (release_evt),
        .long_evt    (long_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic add(input logic b, input int n, input logic [3:0] e, input string nm);
        vec_t v;
        v.btn_n = b;
        v.ncyc  = n;
        v.exp   = e;
        v.name  = nm;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int cyc, input logic [3:0] exp);
        logic [3:0] got;
        got = {pressed, press_evt, release_evt, long_evt};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got {pressed,press,release,long}=%b expected %b", nm, cyc, got, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        btn_n  = 1'b1;

        // Glitch: 3 low samples never reach a full debounce window
        add(1'b0, 3,  4'b0000, "glitch_low");
        add(1'b1, 8,  4'b0000, "glitch_after");
        // Clean press held 15 samples: press at edge 7, release sampled at edge 16 -> release at edge 22
        add(1'b0, 6,  4'b0000, "clean_debounce");
        add(1'b0, 1,  4'b1100, "clean_press_evt");
        add(1'b0, 8,  4'b1000, "clean_held");
        add(1'b1, 6,  4'b1000, "clean_db_up");
        add(1'b1, 1,  4'b0010, "clean_release_evt");
        add(1'b1, 4,  4'b0000, "clean_idle");
        // Long press held 40 samples: long at edge 27, release at edge 47
        add(1'b0, 6,  4'b0000, "long_debounce");
        add(1'b0, 1,  4'b1100, "long_press_evt");
        add(1'b0, 19, 4'b1000, "long_wait");
        add(1'b0, 1,  4'b1001, "long_evt");
        add(1'b0, 13, 4'b1000, "long_no_repeat");
        add(1'b1, 6,  4'b1000, "long_db_up");
        add(1'b1, 1,  4'b0010, "long_release_evt");
        add(1'b1, 4,  4'b0000, "long_idle");
        // Release bounce at samples 11-12 is rejected; long still at edge 27
        add(1'b0, 6,  4'b0000, "rb_debounce");
        add(1'b0, 1,  4'b1100, "rb_press_evt");
        add(1'b0, 3,  4'b1000, "rb_held");
        add(1'b1, 2,  4'b1000, "rb_bounce_high");
        add(1'b0, 14, 4'b1000, "rb_bounce_low");
        add(1'b0, 1,  4'b1001, "rb_long_evt");
        add(1'b0, 3,  4'b1000, "rb_held2");
        add(1'b1, 6,  4'b1000, "rb_db_up");
        add(1'b1, 1,  4'b0010, "rb_release_evt");
        add(1'b1, 4,  4'b0000, "rb_idle");
        // Press bounce train: toggles for 10 samples, final fall at sample 11 -> press at edge 17
        for (int i = 0; i < 5; i++) begin
            add(1'b0, 1, 4'b0000, "train_low");
            add(1'b1, 1, 4'b0000, "train_high");
        end
        add(1'b0, 6,  4'b0000, "train_debounce");
        add(1'b0, 1,  4'b1100, "train_press_evt");
        add(1'b0, 3,  4'b1000, "train_held");
        add(1'b1, 6,  4'b1000, "train_db_up");
        add(1'b1, 1,  4'b0010, "train_release_evt");
        add(1'b1, 4,  4'b0000, "train_idle");

        step();
        step();
        check("reset_state", 0, 4'b0000);
        rst = 1'b0;

        for (int r = 0; r < vecs.size(); r++) begin
            btn_n = vecs[r].btn_n;
            for (int c = 0; c < vecs[r].ncyc; c++) begin
                step();
                check(vecs[r].name, c, vecs[r].exp);
            end
        end

        // Reset mid-hold: outputs drop without a release, fresh press after reset
        btn_n = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            check("mr_debounce", c, 4'b0000);
        end
        step();
        check("mr_press_evt", 7, 4'b1100);
        for (int c = 8; c <= 10; c++) begin
            step();
            check("mr_held", c, 4'b1000);
        end
        rst = 1'b1;
        #1;
        check("mr_reset_async", 0, 4'b0000);
        for (int c = 1; c <= 2; c++) begin
            step();
            check("mr_in_reset", c, 4'b0000);
        end
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            check("mr_post_debounce", c, 4'b0000);
        end
        step();
        check("mr_post_press_evt", 7, 4'b1100);
        for (int c = 8; c <= 9; c++) begin
            step();
            check("mr_post_held", c, 4'b1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
